// File: rtl/player_life_ctrl.sv
// player_life_ctrl
//   Sequences the player's life cycle (IDLE, ALIVE, DYING, RESPAWN, GAME_OVER)
//   and gates keyboard move requests into the player mover. All timing is
//   counted in frames using the startOfFrame pulse.
// Ports:
//   clk, resetN            clock, synchronous active-low reset
//   startOfFrame           one-cycle pulse per frame
//   game_start             start/restart request (level)
//   key_left/right/up/down raw move requests
//   player_hit             collision with enemy/enemy shot (pulse or level)
//   move_left/right/up/down gated move requests (registered)
//   position_reset         one-cycle pulse returning the mover to its start
//   player_visible         sprite draw enable
//   invulnerable           high during RESPAWN
//   lives                  remaining lives
//   game_over              high in GAME_OVER
module player_life_ctrl #(
  parameter int LIVES          = 3,
  parameter int LIVES_WIDTH    = 3,
  parameter int DYING_FRAMES   = 30,
  parameter int RESPAWN_FRAMES = 60,
  parameter int BLINK_FRAMES   = 4
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   game_start,
  input  logic                   key_left,
  input  logic                   key_right,
  input  logic                   key_up,
  input  logic                   key_down,
  input  logic                   player_hit,
  output logic                   move_left,
  output logic                   move_right,
  output logic                   move_up,
  output logic                   move_down,
  output logic                   position_reset,
  output logic                   player_visible,
  output logic                   invulnerable,
  output logic [LIVES_WIDTH-1:0] lives,
  output logic                   game_over
);

  localparam int CNT_MAX = (DYING_FRAMES > RESPAWN_FRAMES) ? DYING_FRAMES : RESPAWN_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BLK_W   = $clog2(BLINK_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ALIVE, S_DYING, S_RESPAWN, S_OVER
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [LIVES_WIDTH-1:0] r_lives, w_lives_nxt;
  logic [CNT_W-1:0]       r_frame, w_frame_nxt, w_frame_inc;
  logic [BLK_W-1:0]       r_blink, w_blink_nxt, w_blink_inc;
  logic                   r_vis, w_vis_nxt;
  logic                   w_prst_nxt;
  logic                   w_mv_en;
  logic [3:0]             r_mv;
  logic                   r_prst, r_inv, r_go;

  assign w_frame_inc = r_frame + CNT_W'(1);
  assign w_blink_inc = r_blink + BLK_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_lives_nxt = r_lives;
    w_frame_nxt = r_frame;
    w_blink_nxt = r_blink;
    w_vis_nxt   = r_vis;
    w_prst_nxt  = 1'b0;
    case (r_state)
      S_IDLE, S_OVER: begin
        w_vis_nxt = 1'b0;
        if (game_start) begin
          w_state_nxt = S_ALIVE;
          w_lives_nxt = LIVES_WIDTH'(LIVES);
          w_frame_nxt = '0;
          w_blink_nxt = '0;
          w_vis_nxt   = 1'b1;
          w_prst_nxt  = 1'b1;
        end
      end
      S_ALIVE: begin
        w_vis_nxt = 1'b1;
        // A hit takes priority over a coincident frame pulse: counter restarts at 0.
        if (player_hit) begin
          w_state_nxt = S_DYING;
          w_lives_nxt = (r_lives != '0) ? r_lives - LIVES_WIDTH'(1) : '0;
          w_frame_nxt = '0;
          w_vis_nxt   = 1'b0;
        end
      end
      S_DYING: begin
        w_vis_nxt = 1'b0;
        if (startOfFrame) begin
          w_frame_nxt = w_frame_inc;
          if (w_frame_inc == CNT_W'(DYING_FRAMES)) begin
            if (r_lives == '0) begin
              w_state_nxt = S_OVER;
            end else begin
              w_state_nxt = S_RESPAWN;
              w_frame_nxt = '0;
              w_blink_nxt = '0;
              w_vis_nxt   = 1'b1;
              w_prst_nxt  = 1'b1;
            end
          end
        end
      end
      S_RESPAWN: begin
        if (startOfFrame) begin
          w_frame_nxt = w_frame_inc;
          // End of invulnerability overrides a blink toggle on the same frame.
          if (w_frame_inc == CNT_W'(RESPAWN_FRAMES)) begin
            w_state_nxt = S_ALIVE;
            w_frame_nxt = '0;
            w_blink_nxt = '0;
            w_vis_nxt   = 1'b1;
          end else if (w_blink_inc == BLK_W'(BLINK_FRAMES)) begin
            w_blink_nxt = '0;
            w_vis_nxt   = ~r_vis;
          end else begin
            w_blink_nxt = w_blink_inc;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs reflect the state being entered, so a hit blocks moves on the next cycle.
  assign w_mv_en = (w_state_nxt == S_ALIVE) || (w_state_nxt == S_RESPAWN);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state <= S_IDLE;
      r_lives <= LIVES_WIDTH'(LIVES);
      r_frame <= '0;
      r_blink <= '0;
      r_vis   <= 1'b0;
      r_mv    <= '0;
      r_prst  <= 1'b0;
      r_inv   <= 1'b0;
      r_go    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lives <= w_lives_nxt;
      r_frame <= w_frame_nxt;
      r_blink <= w_blink_nxt;
      r_vis   <= w_vis_nxt;
      r_prst  <= w_prst_nxt;
      r_inv   <= (w_state_nxt == S_RESPAWN);
      r_go    <= (w_state_nxt == S_OVER);
      // Opposing keys cancel each other.
      r_mv    <= {w_mv_en & key_left  & ~key_right,
                  w_mv_en & key_right & ~key_left,
                  w_mv_en & key_up    & ~key_down,
                  w_mv_en & key_down  & ~key_up};
    end
  end

  assign move_left      = r_mv[3];
  assign move_right     = r_mv[2];
  assign move_up        = r_mv[1];
  assign move_down      = r_mv[0];
  assign position_reset = r_prst;
  assign player_visible = r_vis;
  assign invulnerable   = r_inv;
  assign lives          = r_lives;
  assign game_over      = r_go;

endmodule

// File: doc/player_life_ctrl.md
Name: player_life_ctrl

Overview:
- Controller that sequences the player movement block: it gates the keyboard move requests into the mover and requests position resets.
- Tracks the player's life cycle: idle, alive, dying, respawn (invulnerable, blinking) and game over.
- Sits between the keyboard decoder / collision logic and the player mover and drawing blocks.
- All timing is counted in frames using the 30Hz startOfFrame pulse.

Parameters:
LIVES, 3, lives loaded at game start (1..2^LIVES_WIDTH-1)
LIVES_WIDTH, 3, width of lives output
DYING_FRAMES, 30, frames spent in DYING before respawn or game over (>=1)
RESPAWN_FRAMES, 60, frames of invulnerability after respawn (>=1)
BLINK_FRAMES, 4, frames between visibility toggles during RESPAWN (>=1)

Ports:
clk  in  1  system clock
resetN  in  1  synchronous active-low reset, sampled on posedge clk
startOfFrame  in  1  one-cycle pulse per frame
game_start  in  1  start/restart request (level)
key_left, key_right, key_up, key_down  in  1 each  raw move requests
player_hit  in  1  player collided with enemy/enemy shot (pulse or level)
move_left, move_right, move_up, move_down  out  1 each  gated requests to mover
position_reset  out  1  one-cycle pulse; mover returns to its initial position
player_visible  out  1  drawing enable for player sprite
invulnerable  out  1  high in RESPAWN; collision logic may ignore hits
lives  out  LIVES_WIDTH  remaining lives
game_over  out  1  high in GAME_OVER

Behaviour:
- Reset (resetN=0 at posedge clk):
  - state=IDLE, lives=LIVES, frame counter=0, blink counter=0.
  - All move_* = 0, position_reset=0, player_visible=0, invulnerable=0, game_over=0.
- All outputs are registered. Each move_* follows its key_* one cycle later, only in ALIVE and RESPAWN.
- Opposing keys: if key_left and key_right are both 1, move_left=move_right=0. Same rule for up/down.
- IDLE:
  - Outputs inactive.
  - game_start=1 -> ALIVE, lives=LIVES, position_reset=1 for exactly one cycle, player_visible=1.
  - player_hit is ignored.
- ALIVE:
  - player_visible=1, moves enabled.
  - player_hit=1 -> DYING, lives=lives-1, frame counter cleared, player_visible=0, move_* forced to 0 in the following cycle.
  - If player_hit and startOfFrame coincide, the hit wins and that frame is not counted.
- DYING:
  - Moves 0, player_visible=0.
  - Frame counter increments on each startOfFrame.
  - When the counter reaches DYING_FRAMES (on that startOfFrame cycle):
    - lives==0 -> GAME_OVER.
    - Otherwise -> RESPAWN, with a one-cycle position_reset pulse, frame and blink counters cleared, player_visible=1, invulnerable=1.
  - player_hit is ignored.
- RESPAWN:
  - Moves enabled, invulnerable=1, player_hit ignored.
  - Frame counter increments on each startOfFrame.
  - The blink counter increments on each startOfFrame. When it reaches BLINK_FRAMES it clears and player_visible toggles.
  - When the frame counter reaches RESPAWN_FRAMES -> ALIVE, player_visible=1, invulnerable=0.
- GAME_OVER:
  - game_over=1, moves 0, player_visible=0.
  - game_start=1 -> same action as from IDLE (lives=LIVES, position_reset pulse, ALIVE, game_over=0).
- game_start is ignored in ALIVE, DYING and RESPAWN.
- position_reset never lasts more than one cycle and is asserted only on the transitions listed above.
- lives never wraps below 0; decrement occurs only on the ALIVE->DYING transition.
- A level-held player_hit causes only one life loss, because DYING and RESPAWN ignore it.
- Reset mid-operation (any state) returns immediately to the reset values; no position_reset pulse is generated.

Test Plan:
1. Reset, hold game_start=1 one cycle -> next cycle state ALIVE, lives=3, position_reset=1 for one cycle, player_visible=1; with key_left=1 -> move_left=1 one cycle later.
2. key_left=key_right=1, key_up=1 in ALIVE -> move_left=move_right=0, move_up=1.
3. DYING_FRAMES=2, RESPAWN_FRAMES=4, BLINK_FRAMES=1:
   - player_hit pulse -> lives=2, moves 0, visible 0.
   - After 2 startOfFrame -> position_reset pulse, invulnerable=1.
   - visible toggles each frame (1,0,1,0).
   - After 4 frames -> ALIVE, visible=1, invulnerable=0.
4. player_hit held high for 200 cycles spanning DYING and RESPAWN -> lives decrements only once (3->2).
5. Three hits with full recovery between them -> lives 2,1,0. After the third DYING -> game_over=1, no position_reset. Then game_start -> lives=3, position_reset pulse, ALIVE.
6. Drive resetN=0 in the middle of RESPAWN with startOfFrame and player_hit simultaneously active -> next cycle all outputs at reset values, state IDLE. Also check that player_hit coinciding with startOfFrame in ALIVE enters DYING with the frame counter at 0.
